// File: rtl/rv_pkg.sv
// Shared definitions for the RV64 decode stage: ALU control bit indices,
// major opcodes and the decoded-entry record carried through the ID/EX register.
package rv_pkg;

  localparam int XLEN       = 64;
  localparam int ALU_CTRL_W = 17;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_LUI  = 10;
  localparam int ALU_BEQ  = 11;
  localparam int ALU_BNE  = 12;
  localparam int ALU_BLT  = 13;
  localparam int ALU_BGE  = 14;
  localparam int ALU_BLTU = 15;
  localparam int ALU_BGEU = 16;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]       sr1;
    logic [XLEN-1:0]       sr2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [4:0]            rd;
    logic                  rf_we;
    logic                  is_branch;
    logic                  illegal;
  } entry_t;

  function automatic logic [ALU_CTRL_W-1:0] alu_onehot(input int idx);
    logic [ALU_CTRL_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational decode of one instruction (plus its PC and register reads)
// into a complete ID/EX entry; illegal encodings produce a zeroed op word.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rdata1_i,
  input  logic [XLEN-1:0] rdata2_i,
  output entry_t          entry_o
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       imm_u;
  logic [XLEN-1:0]       imm_b;
  logic                  legal;
  logic                  writes_rd;
  logic [ALU_CTRL_W-1:0] ctrl;
  logic [XLEN-1:0]       sr1;
  logic [XLEN-1:0]       sr2;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{52{inst_i[31]}}, inst_i[31:20]};
  assign imm_u  = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
  assign imm_b  = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  always_comb begin
    legal     = 1'b1;
    writes_rd = 1'b0;
    ctrl      = '0;
    sr1       = rdata1_i;
    sr2       = rdata2_i;
    case (opcode)
      OP: begin
        writes_rd = 1'b1;
        legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        case (funct3)
          3'b000: ctrl = alu_onehot(inst_i[30] ? ALU_SUB : ALU_ADD);
          3'b001: begin ctrl = alu_onehot(ALU_SLL); sr2 = {58'b0, rdata2_i[5:0]}; end
          3'b010: ctrl = alu_onehot(ALU_SLT);
          3'b011: ctrl = alu_onehot(ALU_SLTU);
          3'b100: ctrl = alu_onehot(ALU_XOR);
          3'b101: begin
            ctrl = alu_onehot(inst_i[30] ? ALU_SRA : ALU_SRL);
            sr2  = {58'b0, rdata2_i[5:0]};
          end
          3'b110: ctrl = alu_onehot(ALU_OR);
          default: ctrl = alu_onehot(ALU_AND);
        endcase
      end
      OP_IMM: begin
        writes_rd = 1'b1;
        sr2       = imm_i;
        // No subtract-immediate exists, so inst[30] only matters for right shifts.
        case (funct3)
          3'b000: ctrl = alu_onehot(ALU_ADD);
          3'b001: begin ctrl = alu_onehot(ALU_SLL); sr2 = {58'b0, inst_i[25:20]}; end
          3'b010: ctrl = alu_onehot(ALU_SLT);
          3'b011: ctrl = alu_onehot(ALU_SLTU);
          3'b100: ctrl = alu_onehot(ALU_XOR);
          3'b101: begin
            ctrl = alu_onehot(inst_i[30] ? ALU_SRA : ALU_SRL);
            sr2  = {58'b0, inst_i[25:20]};
          end
          3'b110: ctrl = alu_onehot(ALU_OR);
          default: ctrl = alu_onehot(ALU_AND);
        endcase
      end
      LUI: begin
        writes_rd = 1'b1;
        ctrl      = alu_onehot(ALU_LUI);
        sr1       = '0;
        sr2       = imm_u;
      end
      AUIPC: begin
        writes_rd = 1'b1;
        ctrl      = alu_onehot(ALU_ADD);
        sr1       = pc_i;
        sr2       = imm_u;
      end
      BRANCH: begin
        case (funct3)
          3'b000: ctrl = alu_onehot(ALU_BEQ);
          3'b001: ctrl = alu_onehot(ALU_BNE);
          3'b100: ctrl = alu_onehot(ALU_BLT);
          3'b101: ctrl = alu_onehot(ALU_BGE);
          3'b110: ctrl = alu_onehot(ALU_BLTU);
          3'b111: ctrl = alu_onehot(ALU_BGEU);
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    entry_o    = '0;
    entry_o.pc = pc_i;
    entry_o.rd = inst_i[11:7];
    if (legal) begin
      entry_o.alu_ctrl  = ctrl;
      entry_o.sr1       = sr1;
      entry_o.sr2       = sr2;
      entry_o.is_branch = (opcode == BRANCH);
      entry_o.imm       = (opcode == BRANCH) ? imm_b : '0;
      entry_o.rf_we     = writes_rd && (inst_i[11:7] != 5'd0);
    end else begin
      entry_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with ID/EX output register and a one-entry skid buffer so that
// if_ready comes straight from a flop.
module id_ex_stage
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [XLEN-1:0]       if_pc,
  input  logic [31:0]           if_inst,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic [XLEN-1:0]       rf_rdata2,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [XLEN-1:0]       ex_alu_sr1,
  output logic [XLEN-1:0]       ex_alu_sr2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic [4:0]            ex_rd,
  output logic                  ex_rf_we,
  output logic                  ex_is_branch,
  output logic                  ex_illegal
);

  entry_t dec_entry;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   if_ready_q;
  logic   accept;

  assign rf_raddr1 = if_inst[19:15];
  assign rf_raddr2 = if_inst[24:20];

  rv_decoder u_decoder (
    .inst_i   (if_inst),
    .pc_i     (if_pc),
    .rdata1_i (rf_rdata1),
    .rdata2_i (rf_rdata2),
    .entry_o  (dec_entry)
  );

  assign accept = if_valid && if_ready_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || ex_ready) begin
      // OUT is free this cycle; the skid entry is older and goes first.
      if (skid_valid_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        if (accept) begin
          skid_d = dec_entry;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec_entry;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      if_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      if_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if_ready_q   <= ~skid_valid_d;
    end
  end

  assign if_ready     = if_ready_q;
  assign ex_valid     = out_valid_q;
  assign ex_alu_ctrl  = out_q.alu_ctrl;
  assign ex_alu_sr1   = out_q.sr1;
  assign ex_alu_sr2   = out_q.sr2;
  assign ex_imm       = out_q.imm;
  assign ex_pc        = out_q.pc;
  assign ex_rd        = out_q.rd;
  assign ex_rf_we     = out_q.rf_we;
  assign ex_is_branch = out_q.is_branch;
  assign ex_illegal   = out_q.illegal;

endmodule
